// File: rtl/lcd_driver.sv
// lcd_driver: HD44780-type character LCD timing engine (8-bit bus, write-only).
// After reset it runs the power-on init sequence and then writes one 16-character line.
// While idle it compares the requested mode with the mode on the glass and rewrites
// the line on any difference.
//
// Handshake: none. mode_req is a level. Any difference from mode_disp that is seen in IDLE
// starts a rewrite. lcd_data must be the character code for (mode_disp, cnt) and is
// sampled at sc==0 of each WRITE step.
module lcd_driver #(
  parameter int PWR_CYC  = 20000,
  parameter int STEP_CYC = 50,
  parameter int CLR_CYC  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode_req,
  input  logic [7:0] lcd_data,
  output logic [1:0] mode_disp,
  output logic [3:0] cnt,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_out
);

  localparam int MAXC = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
  localparam int SCW  = $clog2(MAXC);

  typedef enum logic [2:0] {
    POWER_WAIT = 3'd0,
    FUNC_SET   = 3'd1,
    DISP_ON    = 3'd2,
    ENTRY      = 3'd3,
    CLEAR      = 3'd4,
    ADDR1      = 3'd5,
    WRITE      = 3'd6,
    IDLE       = 3'd7
  } state_t;

  state_t           state, state_nxt;
  logic [SCW-1:0]   sc, sc_nxt;
  logic [SCW-1:0]   len_m1;
  logic             last;
  logic             strobed;
  logic [7:0]       cmd;

  assign lcd_rw = 1'b0;

  // Step length, command byte and strobe eligibility for the current state.
  always_comb begin
    len_m1  = SCW'(STEP_CYC - 1);
    cmd     = 8'h00;
    strobed = 1'b1;
    case (state)
      POWER_WAIT: begin
        len_m1  = SCW'(PWR_CYC - 1);
        strobed = 1'b0;
      end
      FUNC_SET: cmd = 8'h38;
      DISP_ON:  cmd = 8'h0C;
      ENTRY:    cmd = 8'h06;
      CLEAR: begin
        cmd    = 8'h01;
        len_m1 = SCW'(CLR_CYC - 1);
      end
      ADDR1:    cmd = 8'h80;
      WRITE:    cmd = 8'h00;
      IDLE:     strobed = 1'b0;
      default:  strobed = 1'b0;
    endcase
    last = (sc == len_m1);
  end

  // Next-state logic: each step runs sc 0..len-1, then the sequence advances.
  always_comb begin
    state_nxt = state;
    sc_nxt    = sc;
    if (state == IDLE) begin
      sc_nxt = '0;
      if (mode_req != mode_disp) state_nxt = ADDR1;
    end else if (last) begin
      sc_nxt = '0;
      case (state)
        POWER_WAIT: state_nxt = FUNC_SET;
        FUNC_SET:   state_nxt = DISP_ON;
        DISP_ON:    state_nxt = ENTRY;
        ENTRY:      state_nxt = CLEAR;
        CLEAR:      state_nxt = ADDR1;
        ADDR1:      state_nxt = WRITE;
        WRITE:      state_nxt = (cnt == 4'd15) ? IDLE : WRITE;
        default:    state_nxt = IDLE;
      endcase
    end else begin
      sc_nxt = sc + 1'b1;
    end
  end

  // State register and step counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= POWER_WAIT;
      sc    <= '0;
    end else begin
      state <= state_nxt;
      sc    <= sc_nxt;
    end
  end

  // Bus, strobe, character index and mode latch.
  // lcd_out/lcd_rs load at the end of sc==0, and E is registered from the sc window,
  // so the bus settles one cycle before E rises and holds until the next step loads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_out   <= 8'h00;
      cnt       <= 4'd0;
      mode_disp <= 2'b00;
      busy      <= 1'b1;
    end else begin
      busy  <= (state_nxt != IDLE);
      lcd_e <= strobed && (sc >= SCW'(1)) && (sc <= SCW'(STEP_CYC / 2));
      if (strobed && (sc == '0)) begin
        lcd_rs  <= (state == WRITE);
        lcd_out <= (state == WRITE) ? lcd_data : cmd;
      end
      if ((state == ADDR1) && (sc == '0)) mode_disp <= mode_req;
      if (state == WRITE) begin
        if (last) cnt <= (cnt == 4'd15) ? 4'd0 : cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
      end
    end
  end

endmodule
